// File: rtl/bru_pipe_u_if.sv
// Issue, bypass, writeback and redirect bundle of the pipelined branch unit.
// Optional perf-counter outputs appear when BRU_PERF_CNT_EN is defined.
interface bru_pipe_u_if #(
    parameter int XLEN        = 64,
    parameter int BYPASS_WID  = 4,
    parameter int IMM_WID     = 32,
    parameter int ROB_IDX_WID = 6,
    parameter int IPR_IDX_WID = 7
);
    localparam int IDX_WID = $clog2(BYPASS_WID);

    logic                   i_vld;
    logic                   o_rdy;
    logic [ROB_IDX_WID-1:0] i_robIdx;
    logic [3:0]             i_micOp;
    logic                   i_rd_wen;
    logic [IPR_IDX_WID-1:0] i_iprd_idx;
    logic [XLEN-1:0]        i_pc;
    logic [IMM_WID-1:0]     i_imm;
    logic                   i_predTaken;
    logic [XLEN-1:0]        i_predTakenpc;
    logic [IDX_WID-1:0]     i_data_idx [2];
    logic [XLEN-1:0]        i_data [BYPASS_WID];
    logic                   i_flush;
    logic                   i_wb_rdy;
    logic                   o_complete;
    logic [ROB_IDX_WID-1:0] o_robIdx;
    logic                   o_wb_vld;
    logic [IPR_IDX_WID-1:0] o_iprd_idx;
    logic [XLEN-1:0]        o_wb_data;
    logic                   o_taken;
    logic                   o_misPred;
    logic [XLEN-1:0]        o_redirect_pc;
`ifdef BRU_PERF_CNT_EN
    logic [63:0]            o_perf_br;
    logic [63:0]            o_perf_mispred;
`endif

    modport master (
        output i_vld, i_robIdx, i_micOp, i_rd_wen, i_iprd_idx, i_pc, i_imm,
               i_predTaken, i_predTakenpc, i_data_idx, i_data, i_flush, i_wb_rdy,
        input  o_rdy, o_complete, o_robIdx, o_wb_vld, o_iprd_idx, o_wb_data,
               o_taken, o_misPred, o_redirect_pc
`ifdef BRU_PERF_CNT_EN
       ,input  o_perf_br, o_perf_mispred
`endif
    );

    modport slave (
        input  i_vld, i_robIdx, i_micOp, i_rd_wen, i_iprd_idx, i_pc, i_imm,
               i_predTaken, i_predTakenpc, i_data_idx, i_data, i_flush, i_wb_rdy,
        output o_rdy, o_complete, o_robIdx, o_wb_vld, o_iprd_idx, o_wb_data,
               o_taken, o_misPred, o_redirect_pc
`ifdef BRU_PERF_CNT_EN
       ,output o_perf_br, o_perf_mispred
`endif
    );
endinterface

// File: rtl/bru_pipe_u.sv
// Two-stage branch/jal/jalr/auipc unit; BRU_PERF_CNT_EN adds branch/mispredict counters.
// Issue to complete in 2 cycles, 1 op/cycle; i_wb_rdy low stalls E2 then E1, dropping o_rdy.
module bru_pipe_u #(
    parameter int XLEN        = 64,
    parameter int BYPASS_WID  = 4,
    parameter int IMM_WID     = 32,
    parameter int ROB_IDX_WID = 6,
    parameter int IPR_IDX_WID = 7
) (
    input  logic         clk,
    input  logic         rst,
    bru_pipe_u_if.slave  bus
);
    localparam int IDX_WID = $clog2(BYPASS_WID);

    localparam logic [3:0] OP_JAL   = 4'd0;
    localparam logic [3:0] OP_JALR  = 4'd1;
    localparam logic [3:0] OP_AUIPC = 4'd2;
    localparam logic [3:0] OP_BEQ   = 4'd3;
    localparam logic [3:0] OP_BNE   = 4'd4;
    localparam logic [3:0] OP_BLT   = 4'd5;
    localparam logic [3:0] OP_BGE   = 4'd6;
    localparam logic [3:0] OP_BLTU  = 4'd7;
    localparam logic [3:0] OP_BGEU  = 4'd8;

    typedef struct packed {
        logic [ROB_IDX_WID-1:0] rob;
        logic [3:0]             op;
        logic                   rd_wen;
        logic [IPR_IDX_WID-1:0] iprd;
        logic [XLEN-1:0]        pc;
        logic [XLEN-1:0]        imm;
        logic                   pred_taken;
        logic [XLEN-1:0]        pred_pc;
        logic [IDX_WID-1:0]     idx0;
        logic [IDX_WID-1:0]     idx1;
    } e1_t;

    typedef struct packed {
        logic [ROB_IDX_WID-1:0] rob;
        logic                   rd_wen;
        logic [IPR_IDX_WID-1:0] iprd;
        logic [XLEN-1:0]        wb_data;
        logic                   taken;
        logic                   mispred;
        logic [XLEN-1:0]        redirect;
`ifdef BRU_PERF_CNT_EN
        logic                   is_br;
`endif
    } e2_t;

    e1_t             e1_q;
    e2_t             e2_q;
    e2_t             e2_d;
    logic            e1_vld;
    logic            e2_vld;
    logic            src_cap;
    logic [XLEN-1:0] hold0;
    logic [XLEN-1:0] hold1;
    logic            e1_adv;
    logic            fire;
    logic [XLEN-1:0] src0;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] fall;
    logic [XLEN-1:0] wb_data;
    logic            taken;
    logic            is_br;

    assign e1_adv    = e1_vld && (!e2_vld || bus.i_wb_rdy);
    assign bus.o_rdy = !e1_vld || e1_adv;
    assign fire      = bus.i_vld && bus.o_rdy;

    // Bypass bus is only valid in the first E1 cycle; later stall cycles use the hold regs.
    assign src0 = src_cap ? hold0 : bus.i_data[e1_q.idx0];
    assign src1 = src_cap ? hold1 : bus.i_data[e1_q.idx1];

    always_comb begin
        br_tgt  = e1_q.pc + e1_q.imm;
        fall    = e1_q.pc + XLEN'(4);
        tgt     = br_tgt;
        taken   = 1'b0;
        is_br   = 1'b1;
        wb_data = '0;
        case (e1_q.op)
            OP_JAL:   begin taken = 1'b1; wb_data = fall; end
            OP_JALR:  begin
                taken   = 1'b1;
                tgt     = (src0 + e1_q.imm) & {{(XLEN-1){1'b1}}, 1'b0};
                wb_data = fall;
            end
            OP_AUIPC: begin is_br = 1'b0; wb_data = br_tgt; end
            OP_BEQ:   taken = (src0 == src1);
            OP_BNE:   taken = (src0 != src1);
            OP_BLT:   taken = ($signed(src0) < $signed(src1));
            OP_BGE:   taken = ($signed(src0) >= $signed(src1));
            OP_BLTU:  taken = (src0 < src1);
            OP_BGEU:  taken = (src0 >= src1);
            default:  is_br = 1'b0;
        endcase
        e2_d.rob      = e1_q.rob;
        e2_d.rd_wen   = e1_q.rd_wen;
        e2_d.iprd     = e1_q.iprd;
        e2_d.wb_data  = wb_data;
        e2_d.taken    = taken;
        e2_d.mispred  = is_br && ((taken != e1_q.pred_taken) || (taken && (tgt != e1_q.pred_pc)));
        e2_d.redirect = taken ? tgt : fall;
`ifdef BRU_PERF_CNT_EN
        e2_d.is_br    = is_br;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e1_vld  <= 1'b0;
            e2_vld  <= 1'b0;
            src_cap <= 1'b0;
            e1_q    <= '0;
            e2_q    <= '0;
            hold0   <= '0;
            hold1   <= '0;
        end else begin
            if (bus.i_flush) begin
                e1_vld  <= 1'b0;
                e2_vld  <= 1'b0;
                src_cap <= 1'b0;
            end else begin
                if (e1_adv)
                    e2_vld <= 1'b1;
                else if (e2_vld && bus.i_wb_rdy)
                    e2_vld <= 1'b0;
                if (fire) begin
                    e1_vld  <= 1'b1;
                    src_cap <= 1'b0;
                end else if (e1_adv) begin
                    e1_vld  <= 1'b0;
                    src_cap <= 1'b0;
                end else if (e1_vld && !src_cap) begin
                    src_cap <= 1'b1;
                end
            end
            if (fire)
                e1_q <= '{rob: bus.i_robIdx, op: bus.i_micOp, rd_wen: bus.i_rd_wen,
                          iprd: bus.i_iprd_idx, pc: bus.i_pc, imm: XLEN'($signed(bus.i_imm)),
                          pred_taken: bus.i_predTaken, pred_pc: bus.i_predTakenpc,
                          idx0: bus.i_data_idx[0], idx1: bus.i_data_idx[1]};
            if (e1_adv)
                e2_q <= e2_d;
            if (e1_vld && !src_cap) begin
                hold0 <= src0;
                hold1 <= src1;
            end
        end
    end

    assign bus.o_complete    = e2_vld;
    assign bus.o_robIdx      = e2_q.rob;
    assign bus.o_wb_vld      = e2_vld && e2_q.rd_wen;
    assign bus.o_iprd_idx    = e2_q.iprd;
    assign bus.o_wb_data     = e2_q.wb_data;
    assign bus.o_taken       = e2_q.taken;
    assign bus.o_misPred     = e2_vld && e2_q.mispred;
    assign bus.o_redirect_pc = e2_q.redirect;

`ifdef BRU_PERF_CNT_EN
    logic [63:0] perf_br;
    logic [63:0] perf_mis;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_br  <= '0;
            perf_mis <= '0;
        end else if (e2_vld && bus.i_wb_rdy && e2_q.is_br) begin
            perf_br <= perf_br + 64'd1;
            if (e2_q.mispred)
                perf_mis <= perf_mis + 64'd1;
        end
    end

    assign bus.o_perf_br      = perf_br;
    assign bus.o_perf_mispred = perf_mis;
`endif
endmodule

// File: tb/tb_bru_pipe_u.sv
// Table-driven bench for bru_pipe_u with an in-order expected-result queue.
module tb_bru_pipe_u;
    localparam logic [3:0] JAL = 4'd0, JALR = 4'd1, AUIPC = 4'd2, BEQ = 4'd3, BNE = 4'd4,
                           BLT = 4'd5, BGE = 4'd6, BLTU = 4'd7, BGEU = 4'd8, UNK = 4'hF;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] M3   = 64'hFFFF_FFFF_FFFF_FFFD;

    typedef struct {
        logic [3:0]  op;
        logic        rw;
        logic [63:0] pc;
        logic [31:0] imm;
        logic [63:0] s0, s1;
        logic        pt;
        logic [63:0] ptpc;
        logic        e_taken, e_mis;
        logic [63:0] e_redir, e_wb;
    } vec_t;

    typedef struct packed {
        logic [5:0]  rob;
        logic        wb_vld;
        logic [6:0]  iprd;
        logic [63:0] wb_data;
        logic        taken;
        logic        mis;
        logic [63:0] redir;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    vec_t tbl[$];
    exp_t exp_q[$];
    int   done_cyc[$];

    bru_pipe_u_if bus ();
    bru_pipe_u dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [191:0] g, input logic [191:0] w);
        total++;
        if (g !== w) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, g, w);
        end
    endtask

    task automatic add(input logic [3:0] op, input logic rw, input logic [63:0] pc,
                       input logic [31:0] imm, input logic [63:0] s0, input logic [63:0] s1,
                       input logic pt, input logic [63:0] ptpc, input logic et,
                       input logic em, input logic [63:0] er, input logic [63:0] ew);
        vec_t r;
        r = '{op, rw, pc, imm, s0, s1, pt, ptpc, et, em, er, ew};
        tbl.push_back(r);
    endtask

    function automatic exp_t mk_exp(input int v, input int rob);
        exp_t e;
        e.rob     = rob[5:0];
        e.wb_vld  = tbl[v].rw;
        e.iprd    = 7'(rob + 10);
        e.wb_data = tbl[v].e_wb;
        e.taken   = tbl[v].e_taken;
        e.mis     = tbl[v].e_mis;
        e.redir   = tbl[v].e_redir;
        return e;
    endfunction

    function automatic exp_t got_now();
        return '{bus.o_robIdx, bus.o_wb_vld, bus.o_iprd_idx, bus.o_wb_data,
                 bus.o_taken, bus.o_misPred, bus.o_redirect_pc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic garbage_bus();
        for (int j = 0; j < 4; j++) bus.i_data[j] = {$urandom, $urandom};
    endtask

    task automatic set_bus(input int v, input int rob);
        garbage_bus();
        bus.i_data[rob % 4]       = tbl[v].s0;
        bus.i_data[(rob + 1) % 4] = tbl[v].s1;
    endtask

    task automatic set_issue(input int v, input int rob, input bit push);
        bus.i_vld         = 1'b1;
        bus.i_robIdx      = rob[5:0];
        bus.i_micOp       = tbl[v].op;
        bus.i_rd_wen      = tbl[v].rw;
        bus.i_iprd_idx    = 7'(rob + 10);
        bus.i_pc          = tbl[v].pc;
        bus.i_imm         = tbl[v].imm;
        bus.i_predTaken   = tbl[v].pt;
        bus.i_predTakenpc = tbl[v].ptpc;
        bus.i_data_idx[0] = 2'(rob % 4);
        bus.i_data_idx[1] = 2'((rob + 1) % 4);
        if (push) exp_q.push_back(mk_exp(v, rob));
    endtask

    // Scoreboard: every accepted completion outside a flush cycle must match the queue head.
    always @(negedge clk) begin
        if (rst && bus.o_complete && bus.i_wb_rdy && !bus.i_flush) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_completion got rob=%0d want none", bus.o_robIdx);
            end else begin
                chk("completion", got_now(), exp_q.pop_front());
                done_cyc.push_back(cyc);
            end
        end
    end

    initial begin : main
        int fi;
        int nv;
        add(BEQ,  0, 64'h1000, 32'h40, 64'd5, 64'd5, 0, 64'h0,    1, 1, 64'h1040, 64'h0);
        add(JALR, 1, 64'h2000, 32'h4, 64'h3001, 64'h0, 1, 64'h3004, 1, 0, 64'h3004, 64'h2004);
        add(BLTU, 0, 64'h3000, 32'h100, ONES, 64'd1, 0, 64'h0,    0, 0, 64'h3004, 64'h0);
        add(BLT,  0, 64'h3000, 32'h100, ONES, 64'd1, 0, 64'h0,    1, 1, 64'h3100, 64'h0);
        add(BNE,  0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h8, 64'd7, 64'd7, 0, 64'h0, 0, 0, 64'h0, 64'h0);
        add(JAL,  1, 64'h4000, 32'hFFFF_FF00, 64'h0, 64'h0, 1, 64'h3F00, 1, 0, 64'h3F00, 64'h4004);
        add(JAL,  1, 64'h4000, 32'h10, 64'h0, 64'h0, 1, 64'h4020, 1, 1, 64'h4010, 64'h4004);
        add(AUIPC,1, 64'h5000, 32'h1234_5000, 64'h0, 64'h0, 1, 64'h0, 0, 0, 64'h5004, 64'h1234_A000);
        add(BGE,  0, 64'h6000, 32'h20, 64'd5, M3, 1, 64'h6020,    1, 0, 64'h6020, 64'h0);
        add(BGEU, 0, 64'h6000, 32'h20, 64'd5, M3, 1, 64'h6020,    0, 1, 64'h6004, 64'h0);
        add(BEQ,  0, 64'h7000, 32'h40, 64'd1, 64'd2, 0, 64'h0,    0, 0, 64'h7004, 64'h0);
        add(BNE,  0, 64'h7000, 32'hFFFF_FFF0, 64'd1, 64'd2, 1, 64'h6FF0, 1, 0, 64'h6FF0, 64'h0);
        add(BLT,  0, 64'h8000, 32'h40, 64'd3, 64'd3, 1, 64'h8040, 0, 1, 64'h8004, 64'h0);
        add(BGE,  0, 64'h8000, 32'h40, 64'd3, 64'd3, 1, 64'h9000, 1, 1, 64'h8040, 64'h0);
        add(BLTU, 0, 64'h8000, 32'h40, 64'd1, 64'd2, 1, 64'h8040, 1, 0, 64'h8040, 64'h0);
        add(BEQ,  0, 64'h8000, 32'h40, 64'd9, 64'd9, 1, 64'h8040, 1, 0, 64'h8040, 64'h0);
        add(UNK,  1, 64'h9000, 32'h4, 64'd1, 64'd1, 1, 64'h0,     0, 0, 64'h9004, 64'h0);
        nv = tbl.size();

        bus.i_vld = 1'b0; bus.i_flush = 1'b0; bus.i_wb_rdy = 1'b1;
        set_issue(0, 0, 0);
        bus.i_vld = 1'b0;
        garbage_bus();
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", {bus.o_rdy, got_now()}, {1'b1, 144'h0});
`ifdef BRU_PERF_CNT_EN
        chk("reset_perf", {bus.o_perf_br, bus.o_perf_mispred}, 128'h0);
`endif
        step();
        rst = 1'b1;

        // Back-to-back table run with the writeback port always ready.
        fi = 0;
        for (int k = 0; k <= nv; k++) begin
            step();
            if (k == 0) fi = cyc;
            if (k < nv) set_issue(k, k, 1); else bus.i_vld = 1'b0;
            if (k > 0) set_bus(k - 1, k - 1); else garbage_bus();
        end
        for (int k = 0; k < 3; k++) begin step(); garbage_bus(); end
        chk("tbl_count", done_cyc.size(), nv);
        if (done_cyc.size() == nv) begin
            chk("tbl_latency", done_cyc[0] - fi, 2);
            chk("tbl_back2back", done_cyc[nv-1] - done_cyc[0], nv - 1);
        end
`ifdef BRU_PERF_CNT_EN
        chk("perf_tbl", {bus.o_perf_br, bus.o_perf_mispred}, {64'd15, 64'd6});
`endif

        // Backpressure: two ops in flight, bus corrupted once E1 has captured its sources.
        step(); set_issue(1, 20, 1); garbage_bus();
        step(); set_issue(3, 21, 1); set_bus(1, 20);
        step(); bus.i_vld = 1'b0; bus.i_wb_rdy = 1'b0; set_bus(3, 21);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin step(); garbage_bus(); end
            @(negedge clk);
            chk("stall_rdy", bus.o_rdy, 1'b0);
            chk("stall_hold", {bus.o_complete, got_now()}, {1'b1, mk_exp(1, 20)});
        end
        step(); bus.i_wb_rdy = 1'b1; garbage_bus();
        for (int k = 0; k < 3; k++) begin step(); garbage_bus(); end
        chk("stall_queue_drained", exp_q.size(), 0);
`ifdef BRU_PERF_CNT_EN
        chk("perf_stall", {bus.o_perf_br, bus.o_perf_mispred}, {64'd17, 64'd7});
`endif

        // Flush with E1 and E2 full while an issue is offered.
        step(); set_issue(0, 30, 0); garbage_bus();
        step(); set_issue(3, 31, 0); set_bus(0, 30); bus.i_wb_rdy = 1'b0;
        step(); set_issue(5, 32, 0); set_bus(3, 31); bus.i_flush = 1'b1;
        @(negedge clk);
        chk("flush_full_rdy", bus.o_rdy, 1'b0);
        step(); bus.i_flush = 1'b0; bus.i_vld = 1'b0; bus.i_wb_rdy = 1'b1; garbage_bus();
        @(negedge clk);
        chk("flush_full_after", {bus.o_complete, bus.o_rdy}, 2'b01);

        // Flush beats a same-cycle accepted issue.
        step(); set_issue(6, 40, 0); garbage_bus();
        step(); set_issue(0, 41, 0); set_bus(6, 40); bus.i_flush = 1'b1;
        @(negedge clk);
        chk("flush_issue_rdy", bus.o_rdy, 1'b1);
        step(); bus.i_flush = 1'b0; bus.i_vld = 1'b0; garbage_bus();
        @(negedge clk);
        chk("flush_issue_after", bus.o_complete, 1'b0);
        for (int k = 0; k < 4; k++) begin step(); garbage_bus(); end

        // Asynchronous reset with both stages occupied.
        step(); set_issue(6, 50, 0); garbage_bus();
        step(); set_issue(0, 51, 0); set_bus(6, 50);
        step(); bus.i_vld = 1'b0; set_bus(0, 51);
        #2 rst = 1'b0;
        #1 chk("midreset_state", {bus.o_rdy, got_now()}, {1'b1, 144'h0});
`ifdef BRU_PERF_CNT_EN
        chk("midreset_perf", {bus.o_perf_br, bus.o_perf_mispred}, 128'h0);
`endif
        step(); step(); rst = 1'b1;
        for (int k = 0; k < 4; k++) begin step(); garbage_bus(); end
        @(negedge clk);
        chk("post_reset_idle", {bus.o_complete, bus.o_rdy}, 2'b01);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
